// File: rtl/ex_mem_stage_if.sv
// EX-to-MEM bundle: EX-side instruction/control inputs and MEM-side registered outputs.
// The slave modport belongs to the pipeline register; the master drives EX and observes MEM.
interface ex_mem_stage_if #(
  parameter int W  = 32,
  parameter int RW = 5,
  parameter int CW = 16
);
  logic          valid_in;
  logic [W-1:0]  alu_out;
  logic          alu_z;
  logic          alu_n;
  logic          alu_v;
  logic [3:0]    cond;
  logic          set_flags;
  logic [RW-1:0] rd_in;
  logic          reg_write_in;
  logic          mem_read_in;
  logic          mem_write_in;
  logic [W-1:0]  store_data_in;
  logic          stall;
  logic          flush;

  logic          valid_out;
  logic [W-1:0]  result_out;
  logic [RW-1:0] rd_out;
  logic          reg_write_out;
  logic          mem_read_out;
  logic          mem_write_out;
  logic [W-1:0]  store_data_out;
  logic [2:0]    flags_nzv;
  logic [CW-1:0] squash_count;

  modport master (
    output valid_in, alu_out, alu_z, alu_n, alu_v, cond, set_flags, rd_in,
           reg_write_in, mem_read_in, mem_write_in, store_data_in, stall, flush,
    input  valid_out, result_out, rd_out, reg_write_out, mem_read_out,
           mem_write_out, store_data_out, flags_nzv, squash_count
  );

  modport slave (
    input  valid_in, alu_out, alu_z, alu_n, alu_v, cond, set_flags, rd_in,
           reg_write_in, mem_read_in, mem_write_in, store_data_in, stall, flush,
    output valid_out, result_out, rd_out, reg_write_out, mem_read_out,
           mem_write_out, store_data_out, flags_nzv, squash_count
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with architectural NZV flags, ARM-style condition
// evaluation, condition-based squash and a saturating squash counter.
module ex_mem_stage #(
  parameter int W  = 32,
  parameter int RW = 5,
  parameter int CW = 16
) (
  input  logic         clk,
  input  logic         rst,
  ex_mem_stage_if.slave bus
);

  logic          r_valid;
  logic [W-1:0]  r_result;
  logic [RW-1:0] r_rd;
  logic          r_reg_write;
  logic          r_mem_read;
  logic          r_mem_write;
  logic [W-1:0]  r_store_data;
  logic [2:0]    r_flags;
  logic [CW-1:0] r_squash;

  logic w_n;
  logic w_z;
  logic w_v;
  logic w_pass;
  logic w_exec;
  logic w_squash;
  logic w_advance;
  logic w_sq_sat;

  assign w_n = r_flags[2];
  assign w_z = r_flags[1];
  assign w_v = r_flags[0];

  // Carry-based codes (2, 3, 8, 9) have no C flag to test and never pass.
  always_comb begin
    w_pass = 1'b0;
    unique case (bus.cond)
      4'd0:    w_pass = w_z;
      4'd1:    w_pass = ~w_z;
      4'd4:    w_pass = w_n;
      4'd5:    w_pass = ~w_n;
      4'd6:    w_pass = w_v;
      4'd7:    w_pass = ~w_v;
      4'd10:   w_pass = (w_n == w_v);
      4'd11:   w_pass = (w_n != w_v);
      4'd12:   w_pass = ~w_z & (w_n == w_v);
      4'd13:   w_pass = w_z | (w_n != w_v);
      4'd14:   w_pass = 1'b1;
      4'd15:   w_pass = 1'b0;
      default: w_pass = 1'b0;
    endcase
  end

  assign w_exec    = bus.valid_in & w_pass;
  assign w_squash  = bus.valid_in & ~w_pass;
  assign w_advance = ~bus.flush & ~bus.stall;
  assign w_sq_sat  = &r_squash;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_result     <= '0;
      r_rd         <= '0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_store_data <= '0;
    end else if (bus.flush) begin
      // Bubble: datapath fields hold, only the side-effect enables are killed.
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else if (!bus.stall) begin
      r_valid      <= w_exec;
      r_result     <= bus.alu_out;
      r_rd         <= bus.rd_in;
      r_reg_write  <= w_exec & bus.reg_write_in;
      r_mem_read   <= w_exec & bus.mem_read_in;
      r_mem_write  <= w_exec & bus.mem_write_in;
      r_store_data <= bus.store_data_in;
    end
  end

  // Flags written here are seen by the next EX instruction without a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags <= 3'b000;
    end else if (w_advance && w_exec && bus.set_flags) begin
      r_flags <= {bus.alu_n, bus.alu_z, bus.alu_v};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_squash <= '0;
    end else if (w_advance && w_squash && !w_sq_sat) begin
      r_squash <= r_squash + CW'(1);
    end
  end

  assign bus.valid_out      = r_valid;
  assign bus.result_out     = r_result;
  assign bus.rd_out         = r_rd;
  assign bus.reg_write_out  = r_reg_write;
  assign bus.mem_read_out   = r_mem_read;
  assign bus.mem_write_out  = r_mem_write;
  assign bus.store_data_out = r_store_data;
  assign bus.flags_nzv      = r_flags;
  assign bus.squash_count   = r_squash;

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Execute-to-memory pipeline register that sits directly downstream of the ALU.
- Captures the ALU result and Z/N/V flags, and holds the architectural NZV flags register.
- Evaluates the ARM-style 4-bit condition field against those flags, and squashes instructions whose condition fails.
- Forwards control and data to the memory stage. Supports stall, flush and a saturating squash counter.

Parameters:
W, 32, datapath width; matches the ALU width parameter.
RW, 5, destination register address width.
CW, 16, squash-counter width.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
valid_in  in  1  EX holds a real instruction.
alu_out  in  W  ALU result.
alu_z  in  1  ALU zero flag.
alu_n  in  1  ALU negative flag.
alu_v  in  1  ALU overflow flag.
cond  in  4  condition code of the EX instruction.
set_flags  in  1  instruction updates NZV (S-bit).
rd_in  in  RW  destination register.
reg_write_in  in  1  register write enable.
mem_read_in  in  1  load.
mem_write_in  in  1  store.
store_data_in  in  W  store data (forwarded rt/rd value).
stall  in  1  hold stage (MEM not ready).
flush  in  1  kill EX instruction (branch redirect).
valid_out  out  1  MEM-stage instruction valid.
result_out  out  W  registered ALU result.
rd_out  out  RW  registered destination.
reg_write_out  out  1  registered write enable, gated by condition.
mem_read_out  out  1  registered load, gated by condition.
mem_write_out  out  1  registered store, gated by condition.
store_data_out  out  W  registered store data.
flags_nzv  out  3  architectural flags {N,Z,V}.
squash_count  out  CW  count of condition-failed instructions.

Behaviour:
- Reset (rst=1 at edge): every output and internal register goes to 0, flags_nzv=3'b000, squash_count=0. Reset overrides stall and flush, and is allowed mid-stream; no in-flight state survives.
- Condition pass is combinational on the current flags_nzv (N,Z,V):
  - 0 EQ: Z. 1 NE: !Z.
  - 4 MI: N. 5 PL: !N.
  - 6 VS: V. 7 VC: !V.
  - 10 GE: N==V. 11 LT: N!=V.
  - 12 GT: !Z & N==V. 13 LE: Z | N!=V.
  - 14 AL: 1. 15 NV: 0.
  - 2, 3, 8, 9 (carry-based, no C flag exists): 0.
- exec = valid_in & pass.
- Per-edge priority is rst > flush > stall > advance.
- flush=1: bubble. valid_out, reg_write_out, mem_read_out and mem_write_out go to 0; result/rd/store_data don't-care (implement as hold). Flags and squash_count are unchanged, even if stall=1.
- stall=1 (no flush): every register holds. Flags and squash_count are unchanged.
- Advance, with latency 1 cycle:
  - valid_out <= exec.
  - result_out <= alu_out. rd_out <= rd_in. store_data_out <= store_data_in.
  - reg_write_out <= exec & reg_write_in. mem_read_out <= exec & mem_read_in. mem_write_out <= exec & mem_write_in.
- Flags update only on advance with exec & set_flags: flags_nzv <= {alu_n, alu_z, alu_v}. Otherwise flags hold.
- The condition uses pre-update flags. A flag-setting instruction at edge k is visible to the instruction in EX on the next cycle, so back-to-back compare-then-conditional needs no bubble.
- squash_count increments on advance when valid_in & !pass. It saturates at 2^CW-1 and does not wrap.
- valid_in=0 on advance produces a bubble and no count.

Test Plan:
1. Reset: drive rst=1 with valid_in=1 and all inputs nonzero -> next cycle every output is 0 and flags_nzv=000; release rst -> the first instruction captured normally.
2. Flag set then conditional: W=8, SUB 57-51 (sel=2, alu_out=6, z=0,n=0,v=0, set_flags=1, cond=AL) -> result_out=6, flags=000. Next instruction cond=GT, reg_write_in=1 -> reg_write_out=1. Then cond=EQ -> valid_out=0, squash_count=1.
3. SUB 0xCC-0xCC with z=1, set_flags=1, followed by store cond=EQ, mem_write_in=1, store_data_in=0x5A -> flags=010, mem_write_out=1, store_data_out=0x5A.
4. Stall: capture result 0x7F, then assert stall 3 cycles while changing inputs and set_flags=1 -> outputs stay 0x7F and flags are unchanged; deassert -> new values captured next edge.
5. Flush with stall: flush=1 and stall=1 together with set_flags=1 and n=1 -> valid_out=0, all write enables 0, flags unchanged.
6. Saturation: CW=2, four cond=NV instructions -> squash_count goes 1, 2, 3, 3; cond 2/8 instructions are also squashed and counted.
